// File: rtl/freq_rx_pkg.sv
// Shared constants and state encodings for the frequency-word UART receiver.
// FREQ_RX_PARITY_EN adds the PARITY byte state (8E1 framing).
package freq_rx_pkg;
  localparam int OVS         = 16;
  localparam int MID_TICK    = 7;
  localparam int HI_MARK_BIT = 7;
  localparam int PAYLOAD_W   = 6;

  typedef logic [2:0] byte_state_t;
  localparam byte_state_t ST_IDLE  = 3'd0;
  localparam byte_state_t ST_START = 3'd1;
  localparam byte_state_t ST_DATA  = 3'd2;
  localparam byte_state_t ST_STOP  = 3'd3;
  localparam byte_state_t ST_BREAK = 3'd4;
`ifdef FREQ_RX_PARITY_EN
  localparam byte_state_t ST_PARITY = 3'd5;
`endif

  typedef logic word_state_t;
  localparam word_state_t WAIT_HI = 1'b0;
  localparam word_state_t WAIT_LO = 1'b1;

  // Rounded clocks per oversample tick.
  function automatic int ovs_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OVS / 2)) / (baud * OVS);
  endfunction
endpackage

// File: rtl/uart_byte_rx.sv
// Synchronizer, 16x tick generator and byte framing FSM.
// FREQ_RX_PARITY_EN inserts an even-parity bit between bit7 and stop.
module uart_byte_rx
  import freq_rx_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);
  localparam int DIV   = ovs_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0] MID_LAST = 4'(MID_TICK);
  localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
`ifdef FREQ_RX_PARITY_EN
  localparam byte_state_t AFTER_DATA = ST_PARITY;
`else
  localparam byte_state_t AFTER_DATA = ST_STOP;
`endif

  logic [1:0]       r_sync;
  logic [DIV_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic             w_rx;
  logic             w_discard;
  byte_state_t      r_state;
  logic [3:0]       r_ovs_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_frame_err;

  assign w_rx   = r_sync[1];
  assign w_tick = (r_tick_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= 2'b11;
      r_tick_cnt <= '0;
    end else begin
      r_sync     <= {r_sync[0], i_rx};
      r_tick_cnt <= w_tick ? DIV_LAST : r_tick_cnt - 1'b1;
    end
  end

`ifdef FREQ_RX_PARITY_EN
  // A parity miss already pulsed frame_err; the stop bit is only consumed.
  logic r_par_err;
  assign w_discard = r_par_err;
`else
  assign w_discard = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ovs_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef FREQ_RX_PARITY_EN
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx) begin
            r_state   <= ST_START;
            r_ovs_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_ovs_cnt == MID_LAST) begin
              r_ovs_cnt <= '0;
              r_bit_cnt <= '0;
              r_state   <= w_rx ? ST_IDLE : ST_DATA;
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_ovs_cnt == OVS_LAST) begin
              r_ovs_cnt <= '0;
              r_shift   <= {w_rx, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) r_state <= AFTER_DATA;
              else r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 4'd1;
            end
          end
        end
`ifdef FREQ_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            if (r_ovs_cnt == OVS_LAST) begin
              r_ovs_cnt   <= '0;
              r_par_err   <= ^{r_shift, w_rx};
              r_frame_err <= ^{r_shift, w_rx};
              r_state     <= ST_STOP;
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 4'd1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_ovs_cnt == OVS_LAST) begin
              r_ovs_cnt <= '0;
              if (w_discard) begin
                r_state <= ST_IDLE;
              end else if (w_rx) begin
                r_byte_valid <= 1'b1;
                r_state      <= ST_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_BREAK;
              end
            end else begin
              r_ovs_cnt <= r_ovs_cnt + 4'd1;
            end
          end
        end
        ST_BREAK: begin
          if (w_rx) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
endmodule

// File: rtl/freq_uart_rx.sv
// Assembles 12-bit frequency words from high/low UART byte pairs.
// Define FREQ_RX_PARITY_EN for even-parity framing in uart_byte_rx.
module freq_uart_rx
  import freq_rx_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [11:0] data_receive,
  output logic        data_valid,
  output logic        frame_err
);
  logic [7:0]           w_byte;
  logic                 w_byte_valid;
  logic                 w_frame_err;
  logic                 w_unused_bit6;
  word_state_t          r_wstate;
  logic [PAYLOAD_W-1:0] r_hi;
  logic [PAYLOAD_W-1:0] r_lo;
  logic                 r_load;

  uart_byte_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_byte_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  assign frame_err     = w_frame_err;
  assign w_unused_bit6 = w_byte[6];

  // The low byte is staged one cycle before the output word loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate     <= WAIT_HI;
      r_hi         <= '0;
      r_lo         <= '0;
      r_load       <= 1'b0;
      data_receive <= '0;
      data_valid   <= 1'b0;
    end else begin
      r_load     <= 1'b0;
      data_valid <= r_load;
      if (r_load) data_receive <= {r_hi, r_lo};
      if (w_frame_err) begin
        r_wstate <= WAIT_HI;
      end else if (w_byte_valid) begin
        if (w_byte[HI_MARK_BIT]) begin
          r_hi     <= w_byte[PAYLOAD_W-1:0];
          r_wstate <= WAIT_LO;
        end else if (r_wstate == WAIT_LO) begin
          r_lo     <= w_byte[PAYLOAD_W-1:0];
          r_load   <= 1'b1;
          r_wstate <= WAIT_HI;
        end
      end
    end
  end
endmodule
